// File: rtl/usb_fs_pkg.sv
// Shared definitions for the USB full-speed protocol engine blocks.
//   arb_state_e : endpoint arbiter FSM state encodings
//   clog2()     : ceiling log2 for sizing parameters at elaboration time
package usb_fs_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

    // Returns ceil(log2(value)); 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/usb_fs_rr_pick.sv
// Combinational winner picker for the endpoint arbiter.
//   req        in  NUM_EPS  eligible requests
//   ptr        in  IDX_W    search start index (round-robin pointer)
//   rr_mode    in  1        1: search from ptr with wrap; 0: lowest index wins
//   win_onehot out NUM_EPS  one-hot winner (0 when nothing requests)
//   win_idx    out IDX_W    winner index (0 when nothing requests)
//   win_valid  out 1        some request was found
module usb_fs_rr_pick
    import usb_fs_pkg::*;
#(
    parameter int NUM_EPS = 4,
    parameter int IDX_W   = (clog2(NUM_EPS) > 1) ? clog2(NUM_EPS) : 1
) (
    input  logic [NUM_EPS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               rr_mode,
    output logic [NUM_EPS-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [IDX_W-1:0]     eff_ptr;
    logic [2*NUM_EPS-1:0] req_dbl;
    logic [NUM_EPS-1:0]   req_rot;

    // Fixed priority is just round-robin with the pointer pinned at 0.
    assign eff_ptr = rr_mode ? ptr : '0;
    // Doubling the vector turns the wrap-around search into a plain shift:
    // bit k of req_rot is request (ptr + k) mod NUM_EPS.
    assign req_dbl = {req, req};
    assign req_rot = NUM_EPS'(req_dbl >> eff_ptr);

    always_comb begin
        int offset;
        int sum;
        win_valid  = 1'b0;
        win_onehot = '0;
        offset     = 0;
        // Descending scan so the last hit is the lowest rotated position.
        for (int i = NUM_EPS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_valid = 1'b1;
                offset    = i;
            end
        end
        sum = int'(eff_ptr) + offset;
        if (sum >= NUM_EPS) begin
            sum = sum - NUM_EPS;
        end
        if (!win_valid) begin
            sum = 0;
        end
        win_idx = IDX_W'(sum);
        if (win_valid) begin
            win_onehot = NUM_EPS'(1) << sum;
        end
    end

endmodule

// File: rtl/usb_fs_ep_arb.sv
// Endpoint arbiter for the USB full-speed protocol engine.
// Grants one of NUM_EPS requesters (fixed priority or round-robin), revokes
// a grant held too long while the engine is idle, and steers the owner's
// data lane to the protocol engine.
//   clk, reset  : clock and synchronous active-high reset
//   ep_req      : per-endpoint request levels
//   ep_grant    : registered one-hot grant
//   ep_data     : endpoint lanes, lane i at [i*DATA_W +: DATA_W]
//   arb_data    : owner's lane, 0 without owner
//   grant_valid : any grant active
//   grant_idx   : owner index, 0 without owner
//   pe_busy     : transaction in flight; freezes re-arbitration and watchdog
//   timeout_err : one-cycle pulse when the watchdog revokes a grant
module usb_fs_ep_arb
    import usb_fs_pkg::*;
#(
    parameter int NUM_EPS  = 4,
    parameter int DATA_W   = 8,
    parameter int RR_MODE  = 1,
    parameter int HOLD_MAX = 0,
    parameter int IDX_W    = (clog2(NUM_EPS) > 1) ? clog2(NUM_EPS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_EPS-1:0]        ep_req,
    output logic [NUM_EPS-1:0]        ep_grant,
    input  logic [NUM_EPS*DATA_W-1:0] ep_data,
    output logic [DATA_W-1:0]         arb_data,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx,
    input  logic                      pe_busy,
    output logic                      timeout_err
);

    localparam int CNT_W = (clog2(HOLD_MAX + 1) > 1) ? clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_EPS - 1);
    localparam bit               WD_ENABLE = (HOLD_MAX > 0);

    arb_state_e         state_q, state_d;
    logic [NUM_EPS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               terr_q, terr_d;
    logic [NUM_EPS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_EPS-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               owner_req;
    logic               wd_hit;
    logic [DATA_W-1:0]  lane [NUM_EPS];

    usb_fs_rr_pick #(
        .NUM_EPS (NUM_EPS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (ep_req & ~mask_q),
        .ptr        (rr_ptr_q),
        .rr_mode    (RR_MODE != 0),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    // Grant is one-hot, so this reads the owner's request without an index.
    assign owner_req = |(ep_req & grant_q);
    assign wd_hit    = WD_ENABLE && (cnt_q == CNT_LAST) && !pe_busy;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        terr_d   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        // A masked endpoint is forgiven once it drops its request.
        mask_d   = mask_q & ep_req;

        case (state_q)
            ARB_IDLE: begin
                if (!pe_busy && pick_valid) begin
                    state_d  = ARB_GRANTED;
                    grant_d  = pick_onehot;
                    idx_d    = pick_idx;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    rr_ptr_d = (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
                end
            end
            ARB_GRANTED: begin
                // Release is checked first so it beats a same-cycle expiry.
                if (!owner_req) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (wd_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                    mask_d  = mask_d | grant_q;
                end else if (WD_ENABLE && !pe_busy) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
            mask_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
            mask_q   <= mask_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EPS; gi++) begin : g_lane
            assign lane[gi] = ep_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Compare-select rather than a variable index so an unowned or unknown
    // lane can never leak onto arb_data.
    always_comb begin
        arb_data = '0;
        if (valid_q) begin
            for (int i = 0; i < NUM_EPS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    arb_data = lane[i];
                end
            end
        end
    end

    assign ep_grant    = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/usb_fs_ep_arb.md
# usb_fs_ep_arb

Parametrised endpoint arbiter for the USB full-speed protocol engine, replacing the combinational fixed-priority IN/OUT arbiters. It grants one of `NUM_EPS` endpoint requesters at a time and supports two arbitration modes: fixed priority and round-robin. It also provides a hold-timeout watchdog and a protocol-engine busy interlock, and steers the owner's data bus to the protocol engine. One instance sits on the IN side and one on the OUT side of `usb_fs_pe`, in the `clk` domain.

## Interface
Parameters:
- `NUM_EPS`, 4: number of requesters, 1..16.
- `DATA_W`, 8: width of each endpoint data lane. The OUT instance uses 1 and leaves the lanes tied to 0.
- `RR_MODE`, 1: 1 selects round-robin; 0 selects fixed priority, where the lowest index wins.
- `HOLD_MAX`, 0: maximum number of cycles a grant may be held while `pe_busy` is low. 0 disables the watchdog.
- `IDX_W`, derived as max(1, clog2(`NUM_EPS`)).

Ports:
- `clk`  in  1  system clock; one clock, all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ep_req`  in  `NUM_EPS`  per-endpoint request level.
- `ep_grant`  out  `NUM_EPS`  one-hot grant, registered.
- `ep_data`  in  `NUM_EPS*DATA_W`  endpoint lanes; lane i is bits [i*DATA_W +: DATA_W].
- `arb_data`  out  `DATA_W`  the owner's lane, or 0 when there is no owner.
- `grant_valid`  out  1  true when any grant is active.
- `grant_idx`  out  `IDX_W`  owner index; 0 when there is no owner.
- `pe_busy`  in  1  a USB transaction is in flight; it freezes re-arbitration and the watchdog.
- `timeout_err`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
State machine with two states:
- **IDLE**
  - If `pe_busy` is 0 and (`ep_req` & ~`mask`) is nonzero, select a winner and move to GRANTED.
  - `ep_grant` rises on the next cycle.
- **GRANTED**
  - Hold the owner while `ep_req[owner]` is 1.
  - When `ep_req[owner]` is 0, go to IDLE and clear the grant on the next edge. This release happens even if `pe_busy` is 1.
  - If `HOLD_MAX` > 0, the counter reaches `HOLD_MAX`-1, `pe_busy` is 0 and the request is still high:
    - revoke the grant;
    - pulse `timeout_err`;
    - set `mask[owner]`;
    - go to IDLE.

Winner selection:
- Fixed priority: the lowest set index wins.
- Round-robin: the first set index at or above `rr_ptr`, wrapping modulo `NUM_EPS`.
  - On every grant, `rr_ptr` becomes winner+1, wrapping to 0 after `NUM_EPS`-1.

Mask:
- `mask[i]` is cleared when `ep_req[i]` is 0.
- A masked endpoint must drop its request before it can win again.

Hold counter:
- Width clog2(`HOLD_MAX`+1).
- Cleared on every grant.
- Increments in GRANTED only while `pe_busy` is 0; it holds while `pe_busy` is 1.

Data path:
- `arb_data` is combinationally muxed from the registered `grant_idx`, gated by `grant_valid`.
- No unknown-state propagation from unowned lanes.

## Timing
- Reset values:
  - `ep_grant`, `grant_valid`, `grant_idx`, `timeout_err`, `arb_data`, `mask`, `rr_ptr` and the counter are all 0.
  - State is IDLE.
- Grant latency:
  - Request high in cycle N with the arbiter idle and not busy gives `ep_grant` high in N+1.
  - Release latency is 1 cycle.
  - From the owner's request dropping to the next grant to a different endpoint takes 2 cycles, because one IDLE cycle is mandatory.
- Simultaneous events:
  - Release and watchdog expiry in the same cycle: release wins, with no error pulse and no mask.
  - Reset asserted mid-grant: all outputs are 0 on the next edge.
- Edge cases:
  - `NUM_EPS`=1: arbitration is trivial and `grant_idx` is constantly 0.
  - `pe_busy` high in IDLE blocks all new grants indefinitely.

## Structure
- Shared package `usb_fs_pkg` holds:
  - arbiter state encodings `ARB_IDLE` and `ARB_GRANTED`;
  - a `clog2` constant function.
- One natural sub-module, `usb_fs_rr_pick`. It is combinational and takes `req`, `ptr` and a mode input. It returns the winner one-hot and index, using a doubled request vector rotated by `ptr`.
- The FSM, mask, counter and data mux stay in `usb_fs_ep_arb`.

## Test plan
- **Reset:** `reset` held 3 cycles with `ep_req`=4'b1111 -> all outputs 0. First edge after release -> `ep_grant`=4'b0001.
- **Round-robin fairness:** `RR_MODE`=1, `ep_req`=4'b1111, each owner drops its request 2 cycles after its grant then reasserts -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
- **Fixed priority:** `RR_MODE`=0, same stimulus -> endpoint 0 is re-granted every time, and endpoints 1..3 are never granted while `ep_req[0]` cycles.
- **Watchdog:** `HOLD_MAX`=8, `ep_req`=4'b0100 held and `pe_busy`=0 -> grant for exactly 8 cycles, then `timeout_err` pulses for 1 cycle. No regrant to endpoint 2 until its request drops then rises.
- **Busy interlock:** grant to endpoint 1 with `pe_busy`=1 for 20 cycles and `HOLD_MAX`=8 -> no timeout. Endpoint 3 requesting meanwhile is not granted until endpoint 1 releases and `pe_busy` falls.
- **Data steering:** `DATA_W`=8, lanes = 8'hA0+i, endpoint 2 granted -> `arb_data`=8'hA2. After release -> `arb_data`=8'h00.
